// File: rtl/ram_arbiter_pkg.sv
// Shared RAM types for the fetch/data arbiter.
// Enum of arbiter states plus an alignment helper.
package ram_arbiter_pkg;

  localparam int WORD_SIZE = 32;
  localparam int WORD_ADDRESS_SIZE = 6;

  typedef logic [WORD_SIZE-1:0] Word;
  typedef logic [WORD_ADDRESS_SIZE+1:0] RamAddress;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ArbState;

  function automatic logic misaligned(
    input RamAddress a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/arb_stats.sv
// Grant and conflict counters for the RAM arbiter.
// Free-running 32-bit counters that wrap.
module arb_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_f,
  input  logic        inc_d,
  input  logic        inc_c,
  output logic [31:0] stat_f_grants,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_conflicts
);

  // Count fetch grants, data grants and contended cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_f_grants  <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (inc_f) stat_f_grants <= stat_f_grants + 32'd1;
      if (inc_d) stat_d_grants <= stat_d_grants + 32'd1;
      if (inc_c) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Fetch/data arbiter for the shared single-port RAM.
// Optional counters under ARB_STATS_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      f_valid,
  input  RamAddress f_addr,
  input  logic      f_flush,
  output logic      f_ready,
  output logic      f_rvalid,
  output Word       f_rdata,
  output logic      f_err,
  input  logic      d_valid,
  input  logic      d_we,
  input  RamAddress d_addr,
  input  Word       d_wdata,
  output logic      d_ready,
  output logic      d_rvalid,
  output Word       d_rdata,
  output logic      d_err,
  output logic      ram_reset,
  output logic      ram_we,
  output RamAddress ram_addr,
  output Word       ram_wdata,
  input  Word       ram_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] stat_f_grants,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_conflicts
`endif
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  ArbState state;
  logic [CW-1:0] starve_cnt;
  logic run;
  logic fetch_ok;
  logic grant_f;
  logic grant_d;
  logic f_mis;
  logic d_mis;

  assign run      = state == RUN;
  assign fetch_ok = f_valid && !f_flush;
  assign grant_f  = run && fetch_ok &&
                    (!d_valid || starve_cnt == LIMIT);
  assign grant_d  = run && d_valid && !grant_f;
  assign f_mis    = misaligned(f_addr);
  assign d_mis    = misaligned(d_addr);

  assign f_ready   = grant_f;
  assign d_ready   = grant_d;
  assign ram_reset = !run;
  assign ram_addr  = grant_f ? f_addr : d_addr;
  assign ram_wdata = d_wdata;
  assign ram_we    = grant_d && d_we && !d_mis;

  // INIT lasts one clock after reset so the RAM clear lands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
    end else begin
      unique case (state)
        INIT: state <= RUN;
        RUN:  state <= RUN;
      endcase
    end
  end

  // Count consecutive cycles fetch loses to data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_f || f_flush || !f_valid) begin
      starve_cnt <= '0;
    end else if (fetch_ok && grant_d && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Register read responses one cycle after acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
      f_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      f_rvalid <= grant_f;
      f_err    <= grant_f && f_mis;
      f_rdata  <= (grant_f && !f_mis) ? ram_rdata : '0;
      d_rvalid <= grant_d;
      d_err    <= grant_d && d_mis;
      d_rdata  <= (grant_d && !d_we && !d_mis) ? ram_rdata : '0;
    end
  end

`ifdef ARB_STATS_EN
  arb_stats u_stats (
    .clk           (clk),
    .reset         (reset),
    .inc_f         (grant_f),
    .inc_d         (grant_d),
    .inc_c         (run && fetch_ok && d_valid),
    .stat_f_grants (stat_f_grants),
    .stat_d_grants (stat_d_grants),
    .stat_conflicts(stat_conflicts)
  );
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM.
// Table vectors plus scoreboard of expected responses.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  typedef struct {
    logic      fv;
    RamAddress fa;
    logic      fl;
    logic      dv;
    logic      we;
    RamAddress da;
    Word       wd;
    logic      ef;
    logic      ed;
  } vec_t;

  typedef struct {
    Word  data;
    logic err;
  } rsp_t;

  logic      clk = 1'b0;
  logic      reset;
  logic      f_valid, f_flush, f_ready, f_rvalid, f_err;
  RamAddress f_addr;
  Word       f_rdata;
  logic      d_valid, d_we, d_ready, d_rvalid, d_err;
  RamAddress d_addr;
  Word       d_wdata, d_rdata;
  logic      ram_reset, ram_we;
  RamAddress ram_addr;
  Word       ram_wdata, ram_rdata;
`ifdef ARB_STATS_EN
  logic [31:0] stat_f_grants, stat_d_grants, stat_conflicts;
`endif

  int errors = 0;
  int checks = 0;

  Word  mem [64];
  Word  shadow [64];
  rsp_t fq[$];
  rsp_t dq[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  ram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .f_valid  (f_valid),
    .f_addr   (f_addr),
    .f_flush  (f_flush),
    .f_ready  (f_ready),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .f_err    (f_err),
    .d_valid  (d_valid),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .ram_reset(ram_reset),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef ARB_STATS_EN
    ,
    .stat_f_grants (stat_f_grants),
    .stat_d_grants (stat_d_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  // Single-port RAM: sync clear, sync write, comb read
  always_ff @(posedge clk) begin
    if (ram_reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_addr[7:2]] <= ram_wdata;
    end
  end

  assign ram_rdata = mem[ram_addr[7:2]];

  task automatic chk(input string n, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", n, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic fv, input RamAddress fa, input logic fl,
    input logic dv, input logic we, input RamAddress da,
    input Word wd, input logic ef, input logic ed);
    vec_t v;
    v.fv = fv; v.fa = fa; v.fl = fl;
    v.dv = dv; v.we = we; v.da = da; v.wd = wd;
    v.ef = ef; v.ed = ed;
    return v;
  endfunction

  task automatic chk_rsp(input int idx);
    rsp_t r;
    chk("f_rvalid", idx, 32'(f_rvalid), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      r = fq.pop_front();
      chk("f_rdata", idx, f_rdata, r.data);
      chk("f_err", idx, 32'(f_err), 32'(r.err));
    end
    chk("d_rvalid", idx, 32'(d_rvalid), 32'(dq.size() != 0));
    if (dq.size() != 0) begin
      r = dq.pop_front();
      chk("d_rdata", idx, d_rdata, r.data);
      chk("d_err", idx, 32'(d_err), 32'(r.err));
    end
  endtask

  // Drive one vector at the negedge, check, predict, advance
  task automatic apply(input vec_t v, input int idx);
    rsp_t r;
    logic exp_we;
    f_valid = v.fv; f_addr = v.fa; f_flush = v.fl;
    d_valid = v.dv; d_we = v.we; d_addr = v.da; d_wdata = v.wd;
    #1;
    chk_rsp(idx);
    chk("f_ready", idx, 32'(f_ready), 32'(v.ef));
    chk("d_ready", idx, 32'(d_ready), 32'(v.ed));
    exp_we = v.ed && v.we && v.da[1:0] == 2'b00;
    chk("ram_we", idx, 32'(ram_we), 32'(exp_we));
    if (v.ef) begin
      r.err = v.fa[1:0] != 2'b00;
      r.data = r.err ? '0 : shadow[v.fa[7:2]];
      fq.push_back(r);
    end
    if (v.ed) begin
      r.err = v.da[1:0] != 2'b00;
      r.data = (v.we || r.err) ? '0 : shadow[v.da[7:2]];
      dq.push_back(r);
      if (exp_we) shadow[v.da[7:2]] = v.wd;
    end
    @(negedge clk);
  endtask

  initial begin
    foreach (shadow[i]) shadow[i] = '0;
    reset = 1'b0;
    f_valid = 1'b1; f_addr = '0; f_flush = 1'b0;
    d_valid = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ram_reset", 0, 32'(ram_reset), 1);
    chk("rst_ram_we", 0, 32'(ram_we), 0);
    chk("rst_f_ready", 0, 32'(f_ready), 0);
    chk("rst_d_ready", 0, 32'(d_ready), 0);
    chk("rst_f_rvalid", 0, 32'(f_rvalid), 0);
    chk("rst_d_rvalid", 0, 32'(d_rvalid), 0);
    chk("rst_f_rdata", 0, f_rdata, 0);
    chk("rst_d_rdata", 0, d_rdata, 0);
    chk("rst_errs", 0, 32'({f_err, d_err}), 0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("init_ram_reset", 0, 32'(ram_reset), 1);
    chk("init_f_ready", 0, 32'(f_ready), 0);
    chk("init_d_ready", 0, 32'(d_ready), 0);
    @(posedge clk);
    #1;
    f_valid = 1'b0; d_valid = 1'b0;
    chk("run_ram_reset", 0, 32'(ram_reset), 0);
    @(negedge clk);

    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h10, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h08, 7, 0, 1));
    tbl.push_back(mk(1, 8'h08, 0, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h20, 32'hdeadbeef, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h20, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h04, 32'h55, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h06, 5, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h04, 0, 0, 1));
    tbl.push_back(mk(1, 8'h02, 0, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h21, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 8'h08, 0, 1, 0, 8'h20, 0,
                       i % 5 == 4, i % 5 != 4));
    tbl.push_back(mk(1, 8'h08, 1, 1, 0, 8'h04, 0, 0, 1));
    tbl.push_back(mk(1, 8'h08, 0, 1, 0, 8'h04, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h04, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 8'h08, 0, 1, 0, 8'h04, 0, i == 4, i != 4));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Accepted load dropped by an asynchronous reset
    f_valid = 1'b0; f_flush = 1'b0;
    d_valid = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    #1;
    chk("mid_d_ready", 100, 32'(d_ready), 1);
    reset = 1'b0;
    #1;
    chk("mid_ram_reset", 100, 32'(ram_reset), 1);
    chk("mid_d_ready_rst", 100, 32'(d_ready), 0);
    @(posedge clk);
    #1;
    chk("mid_d_rvalid", 100, 32'(d_rvalid), 0);
    fq.delete();
    dq.delete();
    foreach (shadow[i]) shadow[i] = '0;
    d_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_run", 101, 32'(ram_reset), 0);
    @(negedge clk);

    for (int i = 0; i < 3; i++)
      apply(mk(1, 8'h08, 0, 1, 0, 8'h20, 0, 0, 1), 200 + i);
    apply(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0), 203);
`ifdef ARB_STATS_EN
    chk("stat_conflicts", 204, stat_conflicts, 3);
    chk("stat_grants", 204, stat_f_grants + stat_d_grants, 3);
`endif
    apply(mk(0, 8'h00, 0, 1, 0, 8'h20, 0, 0, 1), 205);
    apply(mk(1, 8'h08, 0, 0, 0, 8'h00, 0, 1, 0), 206);
    apply(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0), 207);
    chk("sb_empty", 208, 32'(fq.size() + dq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
